// File: rtl/alu_cmd_seq.sv
// Command sequencer driving an ALU operation/data/valid interface and returning results on a valid/ready port.
// Optional self-check of ALU results is built when ALU_SEQ_CHECK_EN is defined.
module alu_cmd_seq #(
    parameter int N_BITS      = 32,
    parameter int RESULT_WAIT = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [N_BITS-1:0] i_cmd_a,
    input  logic [N_BITS-1:0] i_cmd_b,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [N_BITS-1:0] o_rsp_data,
    output logic [1:0]        o_rsp_op,
    output logic              o_rsp_timeout,
    output logic              o_rsp_mismatch,
    output logic [1:0]        o_alu_operation,
    output logic [N_BITS-1:0] o_alu_data_a,
    output logic [N_BITS-1:0] o_alu_data_b,
    output logic              o_alu_valid,
    input  logic [N_BITS-1:0] i_alu_data,
    input  logic              i_alu_valid,
    output logic              o_busy,
    output logic [15:0]       o_cmd_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_VALID,
        WAIT_DATA,
        RESPOND
    } state_t;

    localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(RESULT_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        to_cnt;
    logic [3:0]        settle_cnt;
    logic              cmd_ready_q;
    logic [1:0]        alu_op_q;
    logic [N_BITS-1:0] alu_a_q;
    logic [N_BITS-1:0] alu_b_q;
    logic [N_BITS-1:0] rsp_data_q;
    logic              rsp_timeout_q;
    logic              rsp_mismatch_q;
    logic [15:0]       cmd_count_q;
    logic              accept;
    logic              capture;
    logic              timeout_hit;
    logic              load_settle;
    logic              rsp_done;
    logic              chk_fail;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        load_settle = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (i_alu_valid) begin
                    if (RESULT_WAIT == 0) begin
                        capture   = 1'b1;
                        state_nxt = RESPOND;
                    end else begin
                        load_settle = 1'b1;
                        state_nxt   = WAIT_DATA;
                    end
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESPOND;
                end
            end
            WAIT_DATA: begin
                if (settle_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                if (i_rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [N_BITS-1:0] expected;

    always_comb begin
        expected = '0;
        case (alu_op_q)
            2'b00:   expected = alu_a_q ^ alu_b_q;
            2'b01:   expected = alu_a_q & alu_b_q;
            2'b10:   expected = alu_a_q | alu_b_q;
            default: expected = alu_a_q + alu_b_q;
        endcase
    end

    assign chk_fail = (i_alu_data != expected);
`else
    assign chk_fail = 1'b0;
`endif

    // Ready is registered so it stays low while reset is held and rises one cycle after release.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cmd_ready_q    <= 1'b0;
            alu_op_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            to_cnt         <= '0;
            settle_cnt     <= '0;
            rsp_data_q     <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            cmd_count_q    <= '0;
        end else begin
            cmd_ready_q <= (state_nxt == IDLE);

            if (accept) begin
                alu_op_q <= i_cmd_op;
                alu_a_q  <= i_cmd_a;
                alu_b_q  <= i_cmd_b;
            end

            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT_VALID && !i_alu_valid) begin
                to_cnt <= to_cnt + 8'd1;
            end

            if (load_settle) begin
                settle_cnt <= SETTLE_INIT;
            end else if (state == WAIT_DATA) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                rsp_data_q     <= i_alu_data;
                rsp_timeout_q  <= 1'b0;
                rsp_mismatch_q <= chk_fail;
            end else if (timeout_hit) begin
                rsp_data_q     <= '0;
                rsp_timeout_q  <= 1'b1;
                rsp_mismatch_q <= 1'b0;
            end

            if (rsp_done) begin
                cmd_count_q <= cmd_count_q + 16'd1;
            end
        end
    end

    assign o_cmd_ready     = cmd_ready_q;
    assign o_rsp_valid     = (state == RESPOND);
    assign o_rsp_data      = rsp_data_q;
    assign o_rsp_op        = alu_op_q;
    assign o_rsp_timeout   = rsp_timeout_q;
    assign o_rsp_mismatch  = rsp_mismatch_q;
    assign o_alu_operation = alu_op_q;
    assign o_alu_data_a    = alu_a_q;
    assign o_alu_data_b    = alu_b_q;
    assign o_alu_valid     = (state == ISSUE);
    assign o_busy          = (state != IDLE);
    assign o_cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq with an 8-bit behavioural ALU on the operand interface.
module tb_alu_cmd_seq;

    localparam int NB = 8;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_MM_BAD = 1'b1;
`else
    localparam logic EXP_MM_BAD = 1'b0;
`endif

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op = '0;
    logic [NB-1:0] i_cmd_a = '0;
    logic [NB-1:0] i_cmd_b = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [NB-1:0] o_rsp_data;
    logic [1:0]    o_rsp_op;
    logic          o_rsp_timeout;
    logic          o_rsp_mismatch;
    logic [1:0]    o_alu_operation;
    logic [NB-1:0] o_alu_data_a;
    logic [NB-1:0] o_alu_data_b;
    logic          o_alu_valid;
    logic [NB-1:0] i_alu_data;
    logic          i_alu_valid;
    logic          o_busy;
    logic [15:0]   o_cmd_count;

    logic          alu_vld = 1'b0;
    logic [NB-1:0] alu_res = '0;
    logic          alu_mute = 1'b0;
    logic          force_en = 1'b0;
    logic [NB-1:0] force_val = '0;
    logic          late_vld = 1'b0;
    logic [NB-1:0] late_data = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_cmd_seq #(
        .N_BITS      (NB),
        .RESULT_WAIT (1),
        .TIMEOUT     (15)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_op        (i_cmd_op),
        .i_cmd_a         (i_cmd_a),
        .i_cmd_b         (i_cmd_b),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_op        (o_rsp_op),
        .o_rsp_timeout   (o_rsp_timeout),
        .o_rsp_mismatch  (o_rsp_mismatch),
        .o_alu_operation (o_alu_operation),
        .o_alu_data_a    (o_alu_data_a),
        .o_alu_data_b    (o_alu_data_b),
        .o_alu_valid     (o_alu_valid),
        .i_alu_data      (i_alu_data),
        .i_alu_valid     (i_alu_valid),
        .o_busy          (o_busy),
        .o_cmd_count     (o_cmd_count)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [NB-1:0] alu_f(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a + b;
        endcase
    endfunction

    // Registered ALU: result and valid appear one cycle after o_alu_valid, result holds afterwards.
    always_ff @(posedge i_clock) begin
        if (o_alu_valid && !alu_mute) begin
            alu_vld <= 1'b1;
            alu_res <= force_en ? force_val : alu_f(o_alu_operation, o_alu_data_a, o_alu_data_b);
        end else begin
            alu_vld <= 1'b0;
        end
    end

    assign i_alu_valid = alu_vld | late_vld;
    assign i_alu_data  = late_vld ? late_data : alu_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
        int unsigned guard = 0;
        @(negedge i_clock);
        while (!o_cmd_ready && guard < 50) begin
            @(negedge i_clock);
            guard++;
        end
        if (!o_cmd_ready) check("cmd_ready_wait", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_a     = a;
        i_cmd_b     = b;
        @(posedge i_clock);
        #1 i_cmd_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until o_rsp_valid is seen (bounded).
    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge i_clock);
            lat++;
            if (lat == 1) check({tag, "_alu_valid_c1"}, 32'(o_alu_valid), 32'd1);
            if (lat == 2) check({tag, "_alu_valid_c2"}, 32'(o_alu_valid), 32'd0);
            if (o_rsp_valid) break;
        end
        if (!o_rsp_valid) check({tag, "_rsp_wait"}, 32'(o_rsp_valid), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input int exp_lat, input logic [NB-1:0] exp_data, input logic exp_to,
                           input logic exp_mm);
        int lat;
        send_cmd(op, a, b);
        wait_rsp(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(o_rsp_data), 32'(exp_data));
        check({tag, "_op"}, 32'(o_rsp_op), 32'(op));
        check({tag, "_timeout"}, 32'(o_rsp_timeout), 32'(exp_to));
        check({tag, "_mismatch"}, 32'(o_rsp_mismatch), 32'(exp_mm));
        check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0x0, expected 0x1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge i_clock);
        @(negedge i_clock);
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_alu_valid", 32'(o_alu_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_count", 32'(o_cmd_count), 32'd0);
        check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        check("rel_ready_before_edge", 32'(o_cmd_ready), 32'd0);
        @(negedge i_clock);
        check("rel_ready_after_edge", 32'(o_cmd_ready), 32'd1);

        // Nominal XOR and truncated SUM
        i_rsp_ready = 1'b1;
        run_cmd("xor", 2'b00, 8'hA5, 8'h0F, 4, 8'hAA, 1'b0, 1'b0);
        @(negedge i_clock);
        check("xor_count", 32'(o_cmd_count), 32'd1);
        check("xor_idle", 32'(o_busy), 32'd0);
        run_cmd("sum", 2'b11, 8'hFF, 8'h01, 4, 8'h00, 1'b0, 1'b0);
        @(negedge i_clock);
        check("sum_count", 32'(o_cmd_count), 32'd2);

        // Timeout with a late ALU valid arriving while the response is held
        alu_mute    = 1'b1;
        i_rsp_ready = 1'b0;
        run_cmd("tmo", 2'b10, 8'h12, 8'h34, 17, 8'h00, 1'b1, 1'b0);
        late_data = 8'h5A;
        late_vld  = 1'b1;
        @(negedge i_clock);
        late_vld = 1'b0;
        @(negedge i_clock);
        check("tmo_late_data", 32'(o_rsp_data), 32'h00);
        check("tmo_late_flag", 32'(o_rsp_timeout), 32'd1);
        check("tmo_late_valid", 32'(o_rsp_valid), 32'd1);
        i_rsp_ready = 1'b1;
        @(negedge i_clock);
        check("tmo_idle", 32'(o_busy), 32'd0);
        check("tmo_count", 32'(o_cmd_count), 32'd3);
        alu_mute = 1'b0;

        // Backpressure for 10 cycles, with a competing command offered
        i_rsp_ready = 1'b0;
        run_cmd("bp", 2'b01, 8'hF0, 8'h3C, 4, 8'h30, 1'b0, 1'b0);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b11;
        i_cmd_a     = 8'h11;
        i_cmd_b     = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clock);
            check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(o_rsp_data), 32'h30);
            check("bp_alu_op", 32'(o_alu_operation), 32'd1);
            check("bp_alu_a", 32'(o_alu_data_a), 32'hF0);
            check("bp_alu_b", 32'(o_alu_data_b), 32'h3C);
            check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clock);
        check("bp_idle", 32'(o_busy), 32'd0);
        check("bp_count", 32'(o_cmd_count), 32'd4);
        check("bp_alu_a_retained", 32'(o_alu_data_a), 32'hF0);

        // Faulty ALU result on AND
        force_en  = 1'b1;
        force_val = 8'h31;
        run_cmd("mm", 2'b01, 8'hF0, 8'h3C, 4, 8'h31, 1'b0, EXP_MM_BAD);
        @(negedge i_clock);
        check("mm_count", 32'(o_cmd_count), 32'd5);
        force_en = 1'b0;

        // Reset asserted during WAIT_DATA
        send_cmd(2'b00, 8'h0F, 8'hF0);
        @(negedge i_clock);
        @(negedge i_clock);
        @(negedge i_clock);
        check("rwd_busy_before", 32'(o_busy), 32'd1);
        check("rwd_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
        i_reset = 1'b1;
        #1;
        check("rwd_busy", 32'(o_busy), 32'd0);
        check("rwd_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rwd_alu_valid", 32'(o_alu_valid), 32'd0);
        check("rwd_count", 32'(o_cmd_count), 32'd0);
        check("rwd_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("rwd_rsp_data", 32'(o_rsp_data), 32'd0);
        check("rwd_alu_a", 32'(o_alu_data_a), 32'd0);
        check("rwd_alu_op", 32'(o_alu_operation), 32'd0);
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        run_cmd("post_rst", 2'b00, 8'hA5, 8'h0F, 4, 8'hAA, 1'b0, 1'b0);
        @(negedge i_clock);
        check("post_rst_count", 32'(o_cmd_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that drives the ALU operand interface and collects its results; it is the initiator side of the ALU's operation/data/valid protocol. A host pushes {operation, A, B} commands through a valid/ready port. The sequencer presents each command to the ALU, waits for the ALU valid, and captures the result after a programmable settle delay. It returns the result, with timeout and optional self-check flags, on a valid/ready response port. It runs on the same clock the ALU uses for its interface registers.

## Interface
- N_BITS, 32, operand/result width
- RESULT_WAIT, 1, cycles between ALU valid and result sample (0–15)
- TIMEOUT, 15, cycles to wait for ALU valid before aborting (1–255)

- i_clock  in  1  clock; all state on posedge
- i_reset  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_op  in  2  00 XOR, 01 AND, 10 OR, 11 SUM
- i_cmd_a, i_cmd_b  in  N_BITS  operands
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_rsp_data  out  N_BITS  captured ALU result
- o_rsp_op  out  2  operation of this response
- o_rsp_timeout  out  1  ALU valid never arrived
- o_rsp_mismatch  out  1  self-check failure (see Configuration)
- o_alu_operation  out  2  to ALU i_operation
- o_alu_data_a, o_alu_data_b  out  N_BITS  to ALU operands
- o_alu_valid  out  1  to ALU i_valid
- i_alu_data  in  N_BITS  from ALU o_data
- i_alu_valid  in  1  from ALU o_valid
- o_busy  out  1  state != IDLE
- o_cmd_count  out  16  completed responses, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, ISSUE, WAIT_VALID, WAIT_DATA, RESPOND.
- IDLE: o_cmd_ready=1. On i_cmd_valid&o_cmd_ready, latch op/a/b into the ALU drive registers → ISSUE.
- ISSUE: o_alu_valid=1 for exactly this one cycle; timeout counter cleared → WAIT_VALID.
- WAIT_VALID, with i_alu_valid=1:
  - RESULT_WAIT=0: capture i_alu_data → RESPOND.
  - Otherwise: load settle counter with RESULT_WAIT → WAIT_DATA.
- WAIT_VALID, with i_alu_valid=0: increment the timeout counter. When it reaches TIMEOUT → RESPOND with o_rsp_timeout=1 and o_rsp_data=0.
- WAIT_DATA: decrement the settle counter. On the cycle it reads 1, capture i_alu_data → RESPOND.
- RESPOND: o_rsp_valid=1. Data and flags are held stable until i_rsp_ready=1. At that handshake, o_cmd_count increments → IDLE.
- o_alu_operation/o_alu_data_a/o_alu_data_b change only on command accept. They stay stable from ISSUE through RESPOND and retain their values in IDLE. This is required because the ALU uses its operation input combinationally.
- i_alu_valid is ignored outside WAIT_VALID. A late valid arriving after a timeout is discarded.
- o_cmd_ready=0 in all states except IDLE. Only one command is in flight.

## Timing
- Reset: all outputs 0, FSM=IDLE, counters 0. o_cmd_ready rises the first cycle after reset release.
- Reset mid-operation: immediate return to IDLE, pending response lost, o_alu_valid=0, o_cmd_count=0.
- Nominal latency (RESULT_WAIT=1, i_alu_valid in first WAIT_VALID cycle): accept edge 0; ISSUE in cycle 1; WAIT_VALID in cycle 2; WAIT_DATA in cycle 3; o_rsp_valid high from cycle 4.
- Minimum command-to-command spacing with i_rsp_ready held high: 5 cycles.
- Timeout: o_rsp_valid rises TIMEOUT+2 cycles after the accept edge.

## Configuration
- ALU_SEQ_CHECK_EN defined:
  - A reference model computes the expected result from the latched op/a/b. SUM is (a+b) mod 2^N_BITS.
  - o_rsp_mismatch = (captured != expected) for non-timeout responses, and 0 on timeout.
- ALU_SEQ_CHECK_EN undefined: no model logic is built and o_rsp_mismatch is tied 0.

## Test plan
- N_BITS=8. Send XOR A=0xA5, B=0x0F; ALU model returns 0xAA one cycle after valid → o_rsp_data=0xAA, timeout=0, mismatch=0, o_cmd_count=1.
- SUM A=0xFF, B=0x01 → o_rsp_data=0x00 (truncated). With ALU_SEQ_CHECK_EN, mismatch=0.
- ALU never asserts valid, TIMEOUT=15 → o_rsp_valid at accept+17 cycles, timeout=1, data=0x00. A later i_alu_valid is ignored.
- Backpressure: hold i_rsp_ready=0 for 10 cycles → o_rsp_valid, data, o_alu_* stable, and o_cmd_ready=0 throughout. Then one handshake → IDLE.
- ALU_SEQ_CHECK_EN: AND A=0xF0, B=0x3C; ALU model returns 0x31 → mismatch=1 (expected 0x30).
- Assert i_reset during WAIT_DATA → all outputs 0 immediately. The next command completes normally with o_cmd_count=1.
